// File: rtl/cpci_rp_pkg.sv
// Shared state encoding, error codes and holding-register layout for the
// CPCI reprogramming master.
package cpci_rp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EN_SETUP,
    ST_PROG_LOW,
    ST_WAIT_INIT,
    ST_SHIFT,
    ST_WAIT_DONE,
    ST_FINISH,
    ST_ERROR
  } rp_state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_INIT_TO   = 3'd1;
  localparam logic [2:0] ERR_UNDERRUN  = 3'd2;
  localparam logic [2:0] ERR_INIT_LOST = 3'd3;
  localparam logic [2:0] ERR_DONE_TO   = 3'd4;

  typedef struct packed {
    logic       full;
    logic       last;
    logic [7:0] data;
  } rp_hold_t;

endpackage

// File: rtl/cpci_rp_sync_edge.sv
// Two-flop synchronizer for one asynchronous device pin, with registered
// rise/fall pulses (pulse appears 3 clk after the pin moves).
module cpci_rp_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
      fall <= ~sync[1] & prev;
    end
  end

  assign level = sync[1];

endmodule

// File: rtl/cpci_rp_prog_ctrl.sv
// CPCI reprogramming master: enable -> PROG_B pulse -> INIT_B wait ->
// MSB-first serial shift on device CCLK -> DONE wait.
module cpci_rp_prog_ctrl
  import cpci_rp_pkg::*;
#(
  parameter int EN_SETUP_CYCLES = 16,
  parameter int PROG_B_CYCLES   = 32,
  parameter int INIT_TIMEOUT    = 65535,
  parameter int DONE_TIMEOUT    = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             data_last,
  output logic             data_ready,
  output logic             cpci_rp_en,
  output logic             cpci_rp_prog_b,
  output logic             cpci_rp_din,
  input  logic             cpci_rp_cclk,
  input  logic             cpci_rp_init_b,
  input  logic             cpci_rp_done,
  output logic             busy,
  output logic             prog_ok,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] byte_count
);

  localparam int TMR_MAX = (INIT_TIMEOUT > PROG_B_CYCLES)
    ? ((INIT_TIMEOUT > EN_SETUP_CYCLES) ? INIT_TIMEOUT : EN_SETUP_CYCLES)
    : ((PROG_B_CYCLES > EN_SETUP_CYCLES) ? PROG_B_CYCLES : EN_SETUP_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int DC_W  = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] EN_LAST   = TMR_W'(EN_SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PB_LAST   = TMR_W'(PROG_B_CYCLES - 1);
  localparam logic [TMR_W-1:0] INIT_LAST = TMR_W'(INIT_TIMEOUT - 1);
  localparam logic [DC_W-1:0]  DONE_LAST = DC_W'(DONE_TIMEOUT - 1);

  // index 0 = cclk, 1 = init_b, 2 = done
  logic [2:0] pin_lvl, pin_rise, pin_fall;

  cpci_rp_sync_edge u_sync [2:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     ({cpci_rp_done, cpci_rp_init_b, cpci_rp_cclk}),
    .level   (pin_lvl),
    .rise    (pin_rise),
    .fall    (pin_fall)
  );

  logic cclk_rise, cclk_fall, init_lvl, done_lvl;
  assign cclk_rise = pin_rise[0];
  assign cclk_fall = pin_fall[0];
  assign init_lvl  = pin_lvl[1];
  assign done_lvl  = pin_lvl[2];

  logic unused_sync;
  assign unused_sync = ^{pin_lvl[0], pin_rise[2:1], pin_fall[2:1]};

  rp_state_e        state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [DC_W-1:0]  dcnt, dcnt_n;
  logic [7:0]       sr, sr_n;
  logic             sr_vld, sr_vld_n, sr_last, sr_last_n;
  logic [3:0]       bit_cnt, bit_n;
  rp_hold_t         hold, hold_n;
  logic             last_acc, last_acc_n;
  logic [CNT_W-1:0] bcnt, bcnt_n;
  logic [2:0]       err, err_n;
  logic             ok, ok_n;
  logic             consume;

  always_comb begin
    state_n    = state;
    tmr_n      = tmr + TMR_W'(1);
    dcnt_n     = dcnt;
    sr_n       = sr;
    sr_vld_n   = sr_vld;
    sr_last_n  = sr_last;
    bit_n      = bit_cnt;
    hold_n     = hold;
    last_acc_n = last_acc;
    bcnt_n     = bcnt;
    err_n      = err;
    ok_n       = ok;
    consume    = 1'b0;

    case (state)
      ST_IDLE:
        if (start) begin
          state_n = ST_EN_SETUP;
          tmr_n   = '0;
        end
      ST_EN_SETUP:
        if (tmr == EN_LAST) begin
          state_n = ST_PROG_LOW;
          tmr_n   = '0;
        end
      ST_PROG_LOW:
        if (tmr == PB_LAST) begin
          state_n = ST_WAIT_INIT;
          tmr_n   = '0;
        end
      ST_WAIT_INIT:
        if (init_lvl) begin
          state_n  = ST_SHIFT;
          bit_n    = '0;
          sr_vld_n = 1'b0;
        end else if (tmr == INIT_LAST) begin
          state_n = ST_ERROR;
          err_n   = ERR_INIT_TO;
        end
      ST_SHIFT:
        if (!init_lvl) begin
          state_n = ST_ERROR;
          err_n   = ERR_INIT_LOST;
        end else if (!sr_vld) begin
          // first byte: a rise landing in the load cycle still counts as bit 7
          if (hold.full) begin
            consume   = 1'b1;
            sr_n      = hold.data;
            sr_last_n = hold.last;
            sr_vld_n  = 1'b1;
            bit_n     = cclk_rise ? 4'd1 : 4'd0;
          end else if (cclk_rise) begin
            state_n = ST_ERROR;
            err_n   = ERR_UNDERRUN;
          end
        end else if (cclk_rise) begin
          bit_n = bit_cnt + 4'd1;
        end else if (cclk_fall && bit_cnt == 4'd8) begin
          bcnt_n = (&bcnt) ? bcnt : bcnt + CNT_W'(1);
          if (sr_last) begin
            state_n = ST_WAIT_DONE;
            dcnt_n  = '0;
          end else if (hold.full) begin
            consume   = 1'b1;
            sr_n      = hold.data;
            sr_last_n = hold.last;
            bit_n     = '0;
          end else begin
            state_n = ST_ERROR;
            err_n   = ERR_UNDERRUN;
          end
        end else if (cclk_fall && bit_cnt != 4'd0) begin
          sr_n = {sr[6:0], 1'b0};
        end
      ST_WAIT_DONE:
        if (done_lvl) begin
          state_n = ST_FINISH;
        end else if (cclk_rise) begin
          if (dcnt == DONE_LAST) begin
            state_n = ST_ERROR;
            err_n   = ERR_DONE_TO;
          end else begin
            dcnt_n = dcnt + DC_W'(1);
          end
        end
      ST_FINISH: begin
        ok_n    = 1'b1;
        state_n = ST_IDLE;
      end
      ST_ERROR:
        if (start) begin
          state_n = ST_PROG_LOW;
          tmr_n   = '0;
        end
      default: state_n = ST_IDLE;
    endcase

    data_ready = (state == ST_WAIT_INIT || state == ST_SHIFT) && !last_acc &&
                 (!hold.full || consume);

    if (consume)
      hold_n.full = 1'b0;
    if (data_valid && data_ready) begin
      hold_n     = '{full: 1'b1, last: data_last, data: data_in};
      last_acc_n = last_acc | data_last;
    end

    if (start && (state == ST_IDLE || state == ST_ERROR)) begin
      ok_n       = 1'b0;
      err_n      = ERR_NONE;
      bcnt_n     = '0;
      hold_n     = '0;
      last_acc_n = 1'b0;
    end

    // din idles low outside SHIFT
    if (state_n != ST_SHIFT) begin
      sr_n     = '0;
      sr_vld_n = 1'b0;
    end

    if (abort) begin
      state_n    = ST_IDLE;
      tmr_n      = '0;
      hold_n     = '0;
      last_acc_n = 1'b0;
      sr_n       = '0;
      sr_vld_n   = 1'b0;
      ok_n       = 1'b0;
      err_n      = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      tmr            <= '0;
      dcnt           <= '0;
      sr             <= '0;
      sr_vld         <= 1'b0;
      sr_last        <= 1'b0;
      bit_cnt        <= '0;
      hold           <= '0;
      last_acc       <= 1'b0;
      bcnt           <= '0;
      err            <= ERR_NONE;
      ok             <= 1'b0;
      cpci_rp_en     <= 1'b0;
      cpci_rp_prog_b <= 1'b1;
    end else begin
      state          <= state_n;
      tmr            <= tmr_n;
      dcnt           <= dcnt_n;
      sr             <= sr_n;
      sr_vld         <= sr_vld_n;
      sr_last        <= sr_last_n;
      bit_cnt        <= bit_n;
      hold           <= hold_n;
      last_acc       <= last_acc_n;
      bcnt           <= bcnt_n;
      err            <= err_n;
      ok             <= ok_n;
      cpci_rp_en     <= (state_n != ST_IDLE);
      cpci_rp_prog_b <= (state_n != ST_PROG_LOW);
    end
  end

  assign cpci_rp_din = sr[7];
  assign busy        = (state != ST_IDLE) && (state != ST_ERROR);
  assign error       = (state == ST_ERROR);
  assign prog_ok     = ok;
  assign err_code    = err;
  assign byte_count  = bcnt;

endmodule

// File: tb/tb_cpci_rp_prog_ctrl.sv
// Directed bench: simple CPCI device model (free-running CCLK, INIT_B, DONE,
// MSB-first byte capture) around cpci_rp_prog_ctrl.
module tb_cpci_rp_prog_ctrl;

  localparam int INIT_TO = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0, data_last = 1'b0;
  logic        data_ready;
  logic        cpci_rp_en, cpci_rp_prog_b, cpci_rp_din;
  logic        cpci_rp_cclk = 1'b0;
  logic        init_pin = 1'b0, done_pin = 1'b0;
  logic        busy, prog_ok, error;
  logic [2:0]  err_code;
  logic [15:0] byte_count;

  int n_chk = 0, n_fail = 0;

  bit       dev_cfg = 0, armed = 0, init_en = 0, done_en = 0, init_kill = 0;
  int       rx_count = 0, rx_bits = 0, exp_bytes = 16;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_buf [32];
  bit       feed_stop = 0, feed_active = 0;

  cpci_rp_prog_ctrl #(.INIT_TIMEOUT(INIT_TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .cpci_rp_en(cpci_rp_en),
    .cpci_rp_prog_b(cpci_rp_prog_b), .cpci_rp_din(cpci_rp_din),
    .cpci_rp_cclk(cpci_rp_cclk), .cpci_rp_init_b(init_pin),
    .cpci_rp_done(done_pin), .busy(busy), .prog_ok(prog_ok), .error(error),
    .err_code(err_code), .byte_count(byte_count)
  );

  always #8 clk = ~clk;               // 16-unit system clock
  always #125 cpci_rp_cclk = ~cpci_rp_cclk; // 250-unit device CCLK

  // device captures DIN on CCLK rise
  always @(posedge cpci_rp_cclk) begin
    if (!cpci_rp_prog_b) begin
      rx_count = 0;
      rx_bits  = 0;
    end else if (dev_cfg && init_pin && !done_pin && rx_count < exp_bytes && rx_count < 32) begin
      rx_sh = {rx_sh[6:0], cpci_rp_din};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_buf[rx_count] = rx_sh;
        rx_count++;
        rx_bits = 0;
      end
    end
  end

  // device drives INIT_B / DONE on CCLK fall
  always @(negedge cpci_rp_cclk) begin
    if (!cpci_rp_prog_b) begin
      init_pin = 1'b0;
      done_pin = 1'b0;
      dev_cfg  = 0;
      armed    = 1;
    end else if (init_kill) begin
      init_pin = 1'b0;
    end else if (armed && !dev_cfg && init_en) begin
      init_pin = 1'b1;
      dev_cfg  = 1;
      armed    = 0;
    end else if (dev_cfg && done_en && rx_count == exp_bytes) begin
      done_pin = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic feed(input int n, input bit mark_last);
    bit quit;
    int w;
    feed_active = 1;
    quit = 0;
    for (int i = 0; i < n && !quit; i++) begin
      data_in    = 8'(i);
      data_last  = mark_last && (i == n - 1);
      data_valid = 1'b1;
      w = 0;
      forever begin
        @(negedge clk);
        if (feed_stop || w > 20000) begin quit = 1; break; end
        if (data_ready) begin @(posedge clk); #1; break; end
        w++;
      end
    end
    data_valid  = 1'b0;
    data_last   = 1'b0;
    feed_active = 0;
  endtask

  task automatic stop_feed();
    int w;
    feed_stop = 1;
    w = 0;
    while (feed_active && w < 100) begin @(negedge clk); w++; end
    chk("feed_stop", {31'd0, feed_active}, 0);
    feed_stop = 0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk(tag, {31'd0, busy}, 0);
  endtask

  task automatic measure_prog(output int lead, output int width);
    lead = 0;
    width = 0;
    @(negedge clk);
    while (cpci_rp_prog_b && lead < 200) begin @(negedge clk); lead++; end
    while (!cpci_rp_prog_b && width < 200) begin @(negedge clk); width++; end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_en"},     {31'd0, cpci_rp_en}, 0);
    chk({pfx, "_prog_b"}, {31'd0, cpci_rp_prog_b}, 1);
    chk({pfx, "_din"},    {31'd0, cpci_rp_din}, 0);
    chk({pfx, "_ready"},  {31'd0, data_ready}, 0);
    chk({pfx, "_busy"},   {31'd0, busy}, 0);
    chk({pfx, "_ok"},     {31'd0, prog_ok}, 0);
    chk({pfx, "_error"},  {31'd0, error}, 0);
    chk({pfx, "_code"},   {29'd0, err_code}, 0);
    chk({pfx, "_bcnt"},   {16'd0, byte_count}, 0);
  endtask

  task automatic happy_run(input string pfx);
    int lead, width;
    exp_bytes = 16; init_en = 1; done_en = 1;
    fork feed(16, 1); join_none
    pulse_start();
    chk({pfx, "_en_up"}, {31'd0, cpci_rp_en}, 1);
    measure_prog(lead, width);
    chk({pfx, "_en_lead"}, lead, 16);
    chk({pfx, "_prog_w"}, width, 32);
    wait_end({pfx, "_timeout"}, 10000);
    chk({pfx, "_error"}, {31'd0, error}, 0);
    chk({pfx, "_ok"}, {31'd0, prog_ok}, 1);
    chk({pfx, "_bcnt"}, {16'd0, byte_count}, 16);
    chk({pfx, "_en_off"}, {31'd0, cpci_rp_en}, 0);
    chk({pfx, "_ready"}, {31'd0, data_ready}, 0);
    chk({pfx, "_rx_cnt"}, rx_count, 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_rx%0d", pfx, i), {24'd0, rx_buf[i]}, 32'(i));
    stop_feed();
  endtask

  initial begin
    int lead, width, n;
    #5 reset_n = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    happy_run("happy");

    // INIT_B never rises
    init_en = 0;
    pulse_start();
    measure_prog(lead, width);
    n = 0;
    while (!error && n < INIT_TO + 50) begin @(negedge clk); n++; end
    chk("init_to_cycles", n, INIT_TO);
    chk("init_to_code", {29'd0, err_code}, 1);
    chk("init_to_en_held", {31'd0, cpci_rp_en}, 1);
    chk("init_to_prog_b", {31'd0, cpci_rp_prog_b}, 1);
    pulse_abort();
    @(negedge clk);
    chk("abort_en", {31'd0, cpci_rp_en}, 0);
    chk("abort_error", {31'd0, error}, 0);
    chk("abort_busy", {31'd0, busy}, 0);

    // underrun: three bytes, no last
    init_en = 1; done_en = 1;
    fork feed(3, 0); join_none
    pulse_start();
    wait_end("under_timeout", 10000);
    chk("under_code", {29'd0, err_code}, 2);
    chk("under_bcnt", {16'd0, byte_count}, 3);
    chk("under_error", {31'd0, error}, 1);
    stop_feed();
    // restart from ERROR goes straight to PROG_B low
    pulse_start();
    chk("err_restart_prog_b", {31'd0, cpci_rp_prog_b}, 0);
    chk("err_restart_code", {29'd0, err_code}, 0);
    chk("err_restart_bcnt", {16'd0, byte_count}, 0);
    pulse_abort();
    @(negedge clk);
    chk("abort2_prog_b", {31'd0, cpci_rp_prog_b}, 1);
    chk("abort2_en", {31'd0, cpci_rp_en}, 0);

    // DONE never rises
    done_en = 0;
    fork feed(16, 1); join_none
    pulse_start();
    wait_end("done_to_timeout", 10000);
    chk("done_to_code", {29'd0, err_code}, 4);
    chk("done_to_bcnt", {16'd0, byte_count}, 16);
    chk("done_to_din", {31'd0, cpci_rp_din}, 0);
    stop_feed();
    pulse_abort();

    // INIT_B drops mid-stream
    done_en = 1;
    fork feed(16, 1); join_none
    pulse_start();
    n = 0;
    while (byte_count < 2 && n < 5000) begin @(negedge clk); n++; end
    chk("initlost_reach", {31'd0, byte_count >= 2}, 1);
    repeat (30) @(negedge clk);
    init_kill = 1;
    wait_end("initlost_timeout", 1000);
    chk("initlost_code", {29'd0, err_code}, 3);
    chk("initlost_error", {31'd0, error}, 1);
    init_kill = 0;
    stop_feed();
    pulse_abort();

    // async reset during byte 5, then a clean run
    fork feed(16, 1); join_none
    pulse_start();
    n = 0;
    while (byte_count != 4 && n < 5000) begin @(negedge clk); n++; end
    chk("midrst_reach", {16'd0, byte_count}, 4);
    repeat (40) @(negedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    stop_feed();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    happy_run("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpci_rp_prog_ctrl.md
Name: cpci_rp_prog_ctrl

Overview:
- Synthesizable master that drives the CPCI reprogramming pins (enable, PROG_B, serial DIN) from a byte stream supplied by the register/DMA path.
- Sits directly upstream of the CPCI configuration port.
- Sequences enable → PROG_B pulse → INIT_B wait → MSB-first serial shift clocked by the device-driven CCLK → DONE wait.
- Reports completion or one of several error causes.

Parameters:
- EN_SETUP_CYCLES, 16: clk cycles that cpci_rp_en is held high before PROG_B falls.
- PROG_B_CYCLES, 32: clk cycles PROG_B is held low. Must exceed 300 ns at the system clock rate.
- INIT_TIMEOUT, 65535: clk cycles allowed for INIT_B to rise after PROG_B rises.
- DONE_TIMEOUT, 64: synchronized CCLK rising edges allowed for DONE after the last bit.
- CNT_W, 16: width of byte_count.

Ports:
- clk  in  1  system clock; must be ≥ 8× CCLK frequency
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin programming; accepted in IDLE or ERROR
- abort  in  1  single-cycle pulse; return to IDLE from any state
- data_in  in  8  configuration byte
- data_valid  in  1  data_in valid
- data_last  in  1  qualifies data_in as the final byte
- data_ready  out  1  holding register empty; byte accepted when valid && ready
- cpci_rp_en  out  1  reprogramming enable
- cpci_rp_prog_b  out  1  PROG_B, active low
- cpci_rp_din  out  1  serial configuration data
- cpci_rp_cclk  in  1  configuration clock from device (asynchronous)
- cpci_rp_init_b  in  1  INIT_B from device (asynchronous)
- cpci_rp_done  in  1  DONE from device (asynchronous)
- busy  out  1  state not IDLE/ERROR
- prog_ok  out  1  sticky success; cleared by start or abort
- error  out  1  state == ERROR
- err_code  out  3  0 none, 1 INIT timeout, 2 underrun, 3 INIT_B fell during shift, 4 DONE timeout
- byte_count  out  CNT_W  bytes fully shifted since start; saturates

Behaviour:
- Reset values: cpci_rp_en=0, prog_b=1, din=0, data_ready=0, busy=0, prog_ok=0, error=0, err_code=0, byte_count=0. Reset mid-operation returns to IDLE immediately.
- Input synchronization: cclk, init_b and done each pass through a 2-flop synchronizer plus an edge register. Edge pulses appear 3 clk after the pin transition.
- IDLE: en=0. start → EN_SETUP, with prog_ok, err_code and byte_count cleared.
- EN_SETUP: en=1; hold for EN_SETUP_CYCLES → PROG_LOW.
- PROG_LOW: prog_b=0 for exactly PROG_B_CYCLES clk → WAIT_INIT with prog_b=1.
- WAIT_INIT:
  - data_ready=1 (prefetch allowed).
  - On synchronized init_b high → SHIFT.
  - Counter expires first → ERROR, code 1.
- SHIFT:
  - Shift register sr[7:0]; din = sr[7].
  - On entry, if no byte is held, the state waits for one. It flags underrun (code 2) if a cclk rising edge arrives before a byte loads.
  - Bit counter increments on each synchronized cclk rise. sr shifts left on the next synchronized cclk fall.
  - After the 8th rise, the following fall does three things: loads sr from the holding register, increments byte_count, and reloads the bit counter to 0.
  - If that consumed byte was marked last → WAIT_DONE; din holds 0.
  - Holding register empty at that fall and last not yet sent → ERROR, code 2.
  - Synchronized init_b low during SHIFT → ERROR, code 3.
- WAIT_DONE: synchronized done high → FINISH. DONE_TIMEOUT cclk rises without done → ERROR, code 4.
- FINISH: prog_ok=1; en=0 one cycle later → IDLE.
- ERROR:
  - en held at its current value; prog_b=1; data_ready=0.
  - start → PROG_LOW, skipping EN_SETUP because en is already high.
  - abort → IDLE with en=0.
- Holding register: one byte plus its last flag. Load and consume in the same cycle are permitted. After data_last is accepted, data_ready stays 0 until the next start.
- abort in any state: en=0, prog_b=1, holding register flushed → IDLE. abort wins over a simultaneous start.

Decomposition:
- Package cpci_rp_pkg holds the state encoding (IDLE, EN_SETUP, PROG_LOW, WAIT_INIT, SHIFT, WAIT_DONE, FINISH, ERROR) and the err_code constants.
- Sub-module cpci_rp_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, with reset_n. Instantiated three times.

Test Plan:
- Happy path: stream bytes 0x00..0x0F, last on 0x0F, into the CPCI device model with 250 ns CCLK → model reports success; prog_ok=1; byte_count=16; en returns to 0; no model errors.
- PROG_B timing: clk 62.5 MHz, PROG_B_CYCLES=32 → prog_b low for 512 ns (≥300 ns); en rises 16 clk before prog_b falls.
- INIT timeout: tie init_b low → error=1, err_code=1 after INIT_TIMEOUT clk; then abort → en=0, IDLE.
- Underrun: supply 3 bytes, withhold the 4th (not last) → err_code=2 at the 3rd byte boundary; byte_count=3.
- DONE timeout / INIT_B fault: done stuck 0 after last byte → err_code=4 after 64 CCLK rises. Separately, drop init_b mid-byte → err_code=3.
- Reset mid-shift: assert reset_n=0 during byte 5 → all outputs at reset values asynchronously. A new start then programs 0x00..0x0F successfully.
